// File: rtl/exu2idu_bypass_pkg.sv
// rtl/exu2idu_bypass_pkg.sv - shared forward-select encodings for the EXU->IDU bypass path
package exu2idu_bypass_pkg;

    localparam int FWD_SEL_WIDTH = 2;

    typedef enum logic [FWD_SEL_WIDTH-1:0] {
        FWD_RF  = 2'd0,
        FWD_EXU = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/exu2idu_bypass_bypass_mux.sv
// rtl/exu2idu_bypass_bypass_mux.sv - per-source youngest-first match and operand select
module bypass_mux
    import exu2idu_bypass_pkg::*;
#(
    parameter int CPU_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      ren,
    input  logic [REG_ADDR_WIDTH-1:0] addr,
    input  logic [CPU_WIDTH-1:0]      rf_data,
    input  logic                      exu_vld,
    input  logic                      exu_rdy,
    input  logic [REG_ADDR_WIDTH-1:0] exu_waddr,
    input  logic [CPU_WIDTH-1:0]      exu_data,
    input  logic                      mem_vld,
    input  logic [REG_ADDR_WIDTH-1:0] mem_waddr,
    input  logic [CPU_WIDTH-1:0]      mem_data,
    input  logic                      wb_vld,
    input  logic [REG_ADDR_WIDTH-1:0] wb_waddr,
    input  logic [CPU_WIDTH-1:0]      wb_data,
    output logic [CPU_WIDTH-1:0]      data,
    output fwd_sel_e                  sel,
    output logic                      not_rdy
);

    logic rd_act;
    logic hit_exu;
    logic hit_mem;
    logic hit_wb;

    // x0 is hardwired, so a zero index never takes a bypass
    assign rd_act  = ren & (addr != '0);
    assign hit_exu = rd_act & exu_vld & (exu_waddr == addr);
    assign hit_mem = rd_act & mem_vld & (mem_waddr == addr);
    assign hit_wb  = rd_act & wb_vld  & (wb_waddr  == addr);

    always_comb begin
        sel = FWD_RF;
        if (hit_exu) begin
            sel = FWD_EXU;
        end else if (hit_mem) begin
            sel = FWD_MEM;
        end else if (hit_wb) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        data = rf_data;
        case (sel)
            FWD_EXU: data = exu_data;
            FWD_MEM: data = mem_data;
            FWD_WB:  data = wb_data;
            default: data = rf_data;
        endcase
    end

    assign not_rdy = hit_exu & ~exu_rdy;

endmodule

// File: rtl/exu2idu_bypass.sv
// rtl/exu2idu_bypass.sv - EXU/MEM/WB write tracking, operand forwarding, load-use stall, RF write port
module exu2idu_bypass
    import exu2idu_bypass_pkg::*;
#(
    parameter int CPU_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      exu_en,
    input  logic                      exu_reg_wen,
    input  logic [REG_ADDR_WIDTH-1:0] exu_reg_waddr,
    input  logic                      exu_mem2reg,
    input  logic [CPU_WIDTH-1:0]      exu_alu_res,
    input  logic [CPU_WIDTH-1:0]      mem_rdata,
    input  logic                      flush,
    input  logic                      rs1_ren,
    input  logic                      rs2_ren,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    input  logic [CPU_WIDTH-1:0]      rs1_rf_data,
    input  logic [CPU_WIDTH-1:0]      rs2_rf_data,
    output logic [CPU_WIDTH-1:0]      rs1_data,
    output logic [CPU_WIDTH-1:0]      rs2_data,
    output logic                      idu_stall,
    output logic                      wb_reg_wen,
    output logic [REG_ADDR_WIDTH-1:0] wb_reg_waddr,
    output logic [CPU_WIDTH-1:0]      wb_reg_wdata,
    output logic [CNT_WIDTH-1:0]      stall_cnt
);

    logic                      exu_vld;
    logic                      exu_rdy;

    logic                      mem_vld;
    logic [REG_ADDR_WIDTH-1:0] mem_waddr;
    logic                      mem_load;
    logic [CPU_WIDTH-1:0]      mem_data;
    logic [CPU_WIDTH-1:0]      mem_out;

    logic                      wb_vld;
    logic [REG_ADDR_WIDTH-1:0] wb_waddr;
    logic [CPU_WIDTH-1:0]      wb_data;

    fwd_sel_e                  rs1_sel;
    fwd_sel_e                  rs2_sel;
    logic                      rs1_not_rdy;
    logic                      rs2_not_rdy;

    assign exu_vld = exu_en & exu_reg_wen & (exu_reg_waddr != '0);
    assign exu_rdy = ~exu_mem2reg;

    // Stages advance every cycle; IDU stalls are resolved by a bubble upstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_vld   <= 1'b0;
            mem_waddr <= '0;
            mem_load  <= 1'b0;
            mem_data  <= '0;
            wb_vld    <= 1'b0;
            wb_waddr  <= '0;
            wb_data   <= '0;
        end else begin
            mem_vld   <= exu_vld;
            mem_waddr <= exu_reg_waddr;
            mem_load  <= exu_mem2reg;
            mem_data  <= exu_alu_res;
            wb_vld    <= mem_vld;
            wb_waddr  <= mem_waddr;
            wb_data   <= mem_out;
        end
    end

    assign mem_out = mem_load ? mem_rdata : mem_data;

    assign wb_reg_wen   = wb_vld;
    assign wb_reg_waddr = wb_waddr;
    assign wb_reg_wdata = wb_data;

    bypass_mux #(
        .CPU_WIDTH      (CPU_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_rs1_mux (
        .ren       (rs1_ren),
        .addr      (rs1_addr),
        .rf_data   (rs1_rf_data),
        .exu_vld   (exu_vld),
        .exu_rdy   (exu_rdy),
        .exu_waddr (exu_reg_waddr),
        .exu_data  (exu_alu_res),
        .mem_vld   (mem_vld),
        .mem_waddr (mem_waddr),
        .mem_data  (mem_out),
        .wb_vld    (wb_vld),
        .wb_waddr  (wb_waddr),
        .wb_data   (wb_data),
        .data      (rs1_data),
        .sel       (rs1_sel),
        .not_rdy   (rs1_not_rdy)
    );

    bypass_mux #(
        .CPU_WIDTH      (CPU_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_rs2_mux (
        .ren       (rs2_ren),
        .addr      (rs2_addr),
        .rf_data   (rs2_rf_data),
        .exu_vld   (exu_vld),
        .exu_rdy   (exu_rdy),
        .exu_waddr (exu_reg_waddr),
        .exu_data  (exu_alu_res),
        .mem_vld   (mem_vld),
        .mem_waddr (mem_waddr),
        .mem_data  (mem_out),
        .wb_vld    (wb_vld),
        .wb_waddr  (wb_waddr),
        .wb_data   (wb_data),
        .data      (rs2_data),
        .sel       (rs2_sel),
        .not_rdy   (rs2_not_rdy)
    );

    // Only an unready EXU producer can stall; MEM data is always usable
    assign idu_stall = ~flush & (((rs1_sel == FWD_EXU) & rs1_not_rdy) |
                                 ((rs2_sel == FWD_EXU) & rs2_not_rdy));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (idu_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
